honzales_ctrl: RTL
==================

# honzales_ctrl

Wishbone-programmable run sequencer for the Honzales core in the user project area. It holds the core in reset for a fixed number of cycles, then enables it for a programmed number of cycles. While the core runs, it samples the core's 8-bit output into a small FIFO that the management SoC reads back over Wishbone. It sits between the WB MI A slave port and the Honzales instance, and drives the core's clock-enable and reset.

## Interface
Parameters:
- BASE_ADDR, 32'h3000_0000, block decodes when wbs_adr_i[31:4] == BASE_ADDR[31:4]
- FIFO_DEPTH, 8, sample FIFO entries (power of two, 2..64)
- RST_CYCLES, 4, cycles core_rst is held in RST state (>=1)

Ports:
- wb_clk_i  in  1  single clock
- wb_rst_n  in  1  asynchronous, active-low reset
- wbs_stb_i, wbs_cyc_i, wbs_we_i  in  1 each  Wishbone strobe/cycle/write
- wbs_sel_i  in  4  byte selects (honoured on CTRL and CYCLES writes)
- wbs_dat_i  in  32  write data
- wbs_adr_i  in  32  address
- wbs_ack_o  out  1  acknowledge
- wbs_dat_o  out  32  read data
- core_out  in  8  Honzales io_output
- core_en  out  1  core clock enable
- core_rst  out  1  core reset, active-high
- busy  out  1  state != IDLE
- irq  out  1  run-complete interrupt

## Operation
- Register map (offset = wbs_adr_i[3:2]):
  - 0x0 CTRL:
    - bit0 START: write-1 pulse.
    - bit1 ABORT: write-1 pulse.
    - bit2 CONT: run until abort.
    - bit3 IRQ_EN.
    - [15:8] DIV: sample every DIV+1 run cycles.
    - Reads return the stored bits; START and ABORT read as 0.
  - 0x4 CYCLES: 32-bit run length N, read/write.
  - 0x8 STATUS:
    - bit0 busy.
    - bit1 done: sticky, W1C.
    - bit2 empty.
    - bit3 full.
    - bit4 overflow: sticky, W1C.
    - [15:8] FIFO level.
  - 0xC FIFO: read returns {24'b0, head} and pops. Reading while empty returns 0 and does not pop. Writes are ignored.
- FSM:
  - IDLE → RST on START.
  - RST: core_rst=1 for RST_CYCLES cycles → RUN. Down-counter and divider are cleared on entry.
  - RUN: core_en=1. After N cycles → DONE. With CONT=1, stays in RUN until ABORT. N=0 with CONT=0 → DONE immediately after RST, with zero RUN cycles and no samples.
  - DONE: one cycle, sets done → IDLE.
- START while busy is ignored. ABORT from any state → IDLE next cycle, with core_en=0 and core_rst=0; done is not set. START and ABORT in the same write: ABORT wins.
- Sampling:
  - The divider counts 0..DIV during RUN.
  - When the divider equals DIV, core_out is pushed and the divider resets.
  - With DIV=0 and N=5, exactly 5 samples are pushed.
- FIFO:
  - A push while full with no same-cycle pop is dropped and sets overflow.
  - Push and pop in the same cycle while full: both take effect, level unchanged, no overflow.
  - The FIFO is not cleared by START; reads drain it.
- Unmapped offsets in the decoded window read as 0. Writes to them are acked with no effect.

## Timing
- Reset values: wbs_ack_o=0, wbs_dat_o=0, core_en=0, core_rst=0, busy=0, irq=0, all registers 0, FIFO empty.
- Wishbone handshake:
  - Request valid = cyc & stb & address match & !wbs_ack_o.
  - wbs_ack_o is registered and high for exactly one cycle, the cycle after valid. Back-to-back accesses therefore take 2 cycles each.
  - wbs_dat_o is registered with ack. It is 0 when not acking.
  - Register writes and the FIFO pop take effect at the ack edge.
- START at the ack edge: state=RST from the next cycle. Sequence is RST_CYCLES cycles of core_rst, N cycles of core_en, 1 DONE cycle, then IDLE.
- done, and irq if enabled, rise in the cycle after DONE.
- A STATUS read in the ack cycle of a push or pop reflects the pre-edge level.
- Reset asserted mid-run: all outputs return to reset values immediately (asynchronously). The FIFO contents are lost.

## Configuration
- HONZALES_CTRL_IRQ_EN:
  - Defined: irq = done & IRQ_EN, held until done is cleared via W1C.
  - Undefined: irq tied 0. CTRL bit3 is not stored and reads 0.

## Test plan
- Reset and readback: after reset, read STATUS → 0x0000_0004 (empty only). Write CYCLES=0x1234, read back → 0x1234.
- Basic run: DIV=0, N=3, core_out incrementing from 0x10.
  - Required: core_rst high exactly 4 cycles, then core_en high exactly 3 cycles.
  - FIFO level=3; reads return 0x10, 0x11, 0x12, then 0x00 when empty.
  - done=1.
- Decimation and overflow: DIV=1, N=20, FIFO_DEPTH=8, no reads.
  - Required: 10 pushes, 8 kept, overflow=1, full=1.
  - W1C of STATUS 0x10 clears overflow only.
- Abort: CONT=1, START, ABORT after 7 RUN cycles.
  - Required: IDLE next cycle, core_en=0, done=0, busy=0.
  - A second START while busy is ignored.
- Boundaries: N=0 → RST then DONE, zero samples, done=1. Full FIFO with a simultaneous read pop and push → level stays 8, no overflow.
- IRQ macro: with HONZALES_CTRL_IRQ_EN and IRQ_EN=1, irq rises 1 cycle after DONE and falls after W1C done. Without the macro, irq stays 0 throughout.

Source files
------------

// File: rtl/honzales_ctrl.sv
// honzales_ctrl -- Wishbone-programmable run sequencer for the Honzales core.
//
// Holds the core in reset for RST_CYCLES cycles, then enables it for a
// programmed number of cycles (or until aborted in continuous mode).
// While the core runs, its 8-bit output is decimated into a small sample
// FIFO that the management SoC drains over Wishbone.
//
// Register map (word offset = wbs_adr_i[3:2]):
//   0x0 CTRL   : bit0 START (pulse), bit1 ABORT (pulse), bit2 CONT,
//                bit3 IRQ_EN, [15:8] DIV
//   0x4 CYCLES : 32-bit run length N
//   0x8 STATUS : bit0 busy, bit1 done (W1C), bit2 empty, bit3 full,
//                bit4 overflow (W1C), [15:8] FIFO level
//   0xC FIFO   : read pops {24'b0, head}; reads 0 when empty
//
// Ports:
//   wb_clk_i, wb_rst_n             clock, asynchronous active-low reset
//   wbs_stb_i/cyc_i/we_i/sel_i     Wishbone slave request
//   wbs_adr_i, wbs_dat_i           Wishbone address / write data
//   wbs_ack_o, wbs_dat_o           registered acknowledge / read data
//   core_out                       Honzales io_output, sampled during RUN
//   core_en, core_rst              core clock enable / active-high reset
//   busy                           sequencer not idle
//   irq                            run-complete interrupt
//
// Configuration macro:
//   HONZALES_CTRL_IRQ_EN  when defined, CTRL bit3 is stored and
//                         irq = done & IRQ_EN; otherwise irq is tied low
//                         and CTRL bit3 reads 0.

module honzales_ctrl #(
    parameter logic [31:0] BASE_ADDR  = 32'h3000_0000,
    parameter int          FIFO_DEPTH = 8,
    parameter int          RST_CYCLES = 4
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_n,
    input  logic        wbs_stb_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_dat_i,
    input  logic [31:0] wbs_adr_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    input  logic [7:0]  core_out,
    output logic        core_en,
    output logic        core_rst,
    output logic        busy,
    output logic        irq
);

    localparam int AW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW  = AW + 1;
    localparam int RCW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

    localparam logic [1:0] OFF_CTRL   = 2'd0;
    localparam logic [1:0] OFF_CYCLES = 2'd1;
    localparam logic [1:0] OFF_STATUS = 2'd2;
    localparam logic [1:0] OFF_FIFO   = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RST  = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t state;
    state_t state_next;

    // Wishbone decode
    logic       req;
    logic       wr_req;
    logic       rd_req;
    logic [1:0] offset;
    logic       wr_ctrl;
    logic       wr_cycles;
    logic       wr_status;
    logic       start_cmd;
    logic       abort_cmd;
    logic [31:0] rd_data;

    // Programmable registers
    logic        ctrl_cont;
    logic [7:0]  ctrl_div;
    logic        ctrl_irq_en;
    logic [31:0] cycles_q;
    logic        done_q;
    logic        overflow_q;

    // Sequencing counters
    logic [RCW-1:0] rst_cnt;
    logic [31:0]    run_cnt;
    logic [7:0]     div_cnt;
    logic           rst_last;
    logic           run_last;

    // Sample FIFO
    logic [7:0]    fifo_mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] fifo_count;
    logic          fifo_empty;
    logic          fifo_full;
    logic          sample_push;
    logic          fifo_push;
    logic          fifo_pop;

    logic unused_bits;
    assign unused_bits = &{1'b0, wbs_adr_i[1:0]};

    // A request is only accepted while ack is low, so every access costs
    // exactly one request cycle plus one ack cycle.
    assign offset    = wbs_adr_i[3:2];
    assign req       = wbs_cyc_i && wbs_stb_i && !wbs_ack_o &&
                       (wbs_adr_i[31:4] == BASE_ADDR[31:4]);
    assign wr_req    = req && wbs_we_i;
    assign rd_req    = req && !wbs_we_i;
    assign wr_ctrl   = wr_req && (offset == OFF_CTRL);
    assign wr_cycles = wr_req && (offset == OFF_CYCLES);
    assign wr_status = wr_req && (offset == OFF_STATUS);
    assign start_cmd = wr_ctrl && wbs_sel_i[0] && wbs_dat_i[0];
    assign abort_cmd = wr_ctrl && wbs_sel_i[0] && wbs_dat_i[1];

    assign rst_last = (rst_cnt == RCW'(RST_CYCLES - 1));
    // cycles_q == 0 only reaches RUN in continuous mode; treat it as already
    // expired so clearing CONT mid-run still terminates.
    assign run_last = (cycles_q == 32'd0) || (run_cnt >= (cycles_q - 32'd1));

    // State register.
    always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and core control outputs. ABORT overrides everything,
    // including a START carried in the same write.
    always_comb begin
        state_next = state;
        core_en    = 1'b0;
        core_rst   = 1'b0;
        busy       = (state != ST_IDLE);
        case (state)
            ST_IDLE: begin
                if (start_cmd) begin
                    state_next = ST_RST;
                end
            end
            ST_RST: begin
                core_rst = 1'b1;
                if (rst_last) begin
                    if ((cycles_q == 32'd0) && !ctrl_cont) begin
                        state_next = ST_DONE;
                    end else begin
                        state_next = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                core_en = 1'b1;
                if (!ctrl_cont && run_last) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
        if (abort_cmd) begin
            state_next = ST_IDLE;
        end
    end

    // Counters are held at zero outside their state, so they are always
    // clear on entry to RST or RUN.
    always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            rst_cnt <= '0;
            run_cnt <= '0;
            div_cnt <= '0;
        end else begin
            if (state == ST_RST) begin
                rst_cnt <= rst_cnt + 1'b1;
            end else begin
                rst_cnt <= '0;
            end
            if (state == ST_RUN) begin
                run_cnt <= run_cnt + 32'd1;
                if (div_cnt == ctrl_div) begin
                    div_cnt <= '0;
                end else begin
                    div_cnt <= div_cnt + 8'd1;
                end
            end else begin
                run_cnt <= '0;
                div_cnt <= '0;
            end
        end
    end

    // CTRL and CYCLES registers with byte-lane enables.
    always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            ctrl_cont <= 1'b0;
            ctrl_div  <= '0;
            cycles_q  <= '0;
        end else begin
            if (wr_ctrl) begin
                if (wbs_sel_i[0]) begin
                    ctrl_cont <= wbs_dat_i[2];
                end
                if (wbs_sel_i[1]) begin
                    ctrl_div <= wbs_dat_i[15:8];
                end
            end
            if (wr_cycles) begin
                for (int b = 0; b < 4; b++) begin
                    if (wbs_sel_i[b]) begin
                        cycles_q[b*8 +: 8] <= wbs_dat_i[b*8 +: 8];
                    end
                end
            end
        end
    end

`ifdef HONZALES_CTRL_IRQ_EN
    logic irq_en_q;

    always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            irq_en_q <= 1'b0;
        end else if (wr_ctrl && wbs_sel_i[0]) begin
            irq_en_q <= wbs_dat_i[3];
        end
    end

    assign ctrl_irq_en = irq_en_q;
    assign irq         = done_q && irq_en_q;
`else
    assign ctrl_irq_en = 1'b0;
    assign irq         = 1'b0;
`endif

    // Sticky status flags; a hardware set wins over a same-cycle W1C.
    always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            done_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            if (wr_status && wbs_dat_i[1]) begin
                done_q <= 1'b0;
            end
            if ((state == ST_DONE) && !abort_cmd) begin
                done_q <= 1'b1;
            end
            if (wr_status && wbs_dat_i[4]) begin
                overflow_q <= 1'b0;
            end
            if (sample_push && fifo_full && !fifo_pop) begin
                overflow_q <= 1'b1;
            end
        end
    end

    // A push into a full FIFO is still accepted when a pop frees the slot
    // on the same edge.
    assign fifo_empty  = (fifo_count == '0);
    assign fifo_full   = (fifo_count == CW'(FIFO_DEPTH));
    assign sample_push = (state == ST_RUN) && (div_cnt == ctrl_div);
    assign fifo_pop    = rd_req && (offset == OFF_FIFO) && !fifo_empty;
    assign fifo_push   = sample_push && (!fifo_full || fifo_pop);

    always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (fifo_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (fifo_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({fifo_push, fifo_pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // Storage carries no reset; the pointers define what is valid.
    always_ff @(posedge wb_clk_i) begin
        if (fifo_push) begin
            fifo_mem[wr_ptr] <= core_out;
        end
    end

    // Read mux built from pre-edge state, so a STATUS read that coincides
    // with a push or pop reports the level before that edge.
    always_comb begin
        rd_data = '0;
        case (offset)
            OFF_CTRL: begin
                rd_data = {16'h0, ctrl_div, 4'h0, ctrl_irq_en, ctrl_cont, 2'b00};
            end
            OFF_CYCLES: begin
                rd_data = cycles_q;
            end
            OFF_STATUS: begin
                rd_data = {16'h0, 8'(fifo_count), 3'b000, overflow_q,
                           fifo_full, fifo_empty, done_q, busy};
            end
            OFF_FIFO: begin
                if (!fifo_empty) begin
                    rd_data = {24'h0, fifo_mem[rd_ptr]};
                end
            end
            default: begin
                rd_data = '0;
            end
        endcase
    end

    // Registered acknowledge; read data is only non-zero alongside ack.
    always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            wbs_ack_o <= 1'b0;
            wbs_dat_o <= '0;
        end else begin
            wbs_ack_o <= req;
            wbs_dat_o <= rd_req ? rd_data : 32'h0;
        end
    end

endmodule
